// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue
//   Instruction-fetch front end for the 5-stage MIPS pipeline. It sits directly
//   upstream of the IF/ID register. It owns the PC and reads words from a
//   synchronous instruction memory with a 1-cycle read latency. Returned
//   instructions are buffered, together with their PC, in a DEPTH-entry FIFO.
//   The head of the FIFO is presented to decode.
//
//   Handshake: an instruction moves to decode on a rising clk edge where
//   id_valid && id_ready are both high. While id_valid is high and id_ready is
//   low, the head fields are held stable. id_valid never depends on id_ready.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   imem_req       instruction memory read request this cycle
//   imem_addr      word address (pc[IMEM_AW+1:2])
//   imem_rdata     read data, valid the cycle after imem_req
//   redirect_valid taken branch/jump: flush the queue and refetch
//   redirect_pc    new PC (bits [1:0] ignored)
//   id_ready       decode accepts the head instruction (0 = stall)
//   id_valid       head instruction valid
//   id_instr       head instruction word (0 when !id_valid)
//   id_pc          PC of the head instruction (0 when !id_valid)
//   id_pc_plus4    id_pc + 4, modulo 2^32 (0 when !id_valid)
module mips_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [31:0]        id_instr,
  output logic [31:0]        id_pc,
  output logic [31:0]        id_pc_plus4
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   pc;
  logic [31:0]   reqPc;
  logic          inflight;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW:0]   count;
  logic [31:0]   instrMem [DEPTH];
  logic [31:0]   pcMem    [DEPTH];

  logic          push;
  logic          pop;
  logic [PW+1:0] used;

  // Credit: a request is only issued if its response is guaranteed a slot.
  // A pop in the same cycle is deliberately not counted as freed space, which
  // keeps the issue path independent of id_ready.
  assign used     = {1'b0, count} + {{(PW + 1){1'b0}}, inflight};
  assign imem_req = rst && !redirect_valid && (used < (PW + 2)'(DEPTH));
  assign imem_addr = pc[IMEM_AW+1:2];

  // A redirect discards the in-flight response and any concurrent pop.
  assign push     = inflight && !redirect_valid;
  assign id_valid = (count != '0);
  assign pop      = id_valid && id_ready && !redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      reqPc    <= '0;
      inflight <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~32'd3;
      inflight <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
    end else begin
      if (imem_req) begin
        reqPc    <= pc;
        pc       <= pc + 32'd4;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: a slot is only read once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr] <= imem_rdata;
      pcMem[wrPtr]    <= reqPc;
    end
  end

  always_comb begin
    id_instr    = '0;
    id_pc       = '0;
    id_pc_plus4 = '0;
    if (id_valid) begin
      id_instr    = instrMem[rdPtr];
      id_pc       = pcMem[rdPtr];
      id_pc_plus4 = pcMem[rdPtr] + 32'd4;
    end
  end

  // The credit scheme must make a push into a full queue impossible.
  assert property (@(posedge clk) disable iff (!rst)
                   push |-> (count != (PW + 1)'(DEPTH)));

endmodule
